// File: rtl/lmx_spi_reader.sv
// lmx_spi_reader: LMX2594 register readback SPI master; optional MISO synchronizer via LMX_SPI_READER_MISO_SYNC_EN
module lmx_spi_reader #(
   parameter int clk_div = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_start,
   input  logic [6:0]  rd_addr,
   output logic        rd_ready,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        spi_sclk,
   output logic        spi_mosi,
   output logic        spi_le,
   input  logic        spi_miso
);
   localparam logic [7:0] L = 8'((clk_div + 1) / 2);
   localparam logic [7:0] H = 8'(clk_div / 2);
   localparam logic [7:0] P = 8'(clk_div);
   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TAIL, GAP} state_t;
   state_t      state;
   logic [7:0]  ph;
   logic [4:0]  bits;
   logic [23:0] frame;
   logic [15:0] sh;
   logic        miso_s;
`ifdef LMX_SPI_READER_MISO_SYNC_EN
   logic [1:0]  sync;
   if (clk_div < 6 || clk_div > 255) begin : g_bad_div
      $error("lmx_spi_reader: clk_div must be 6..255 with the MISO synchronizer");
   end
   // two-flop synchronizer on the asynchronous MUXout readback
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= 2'b00;
      else sync <= {sync[0], spi_miso};
   assign miso_s = sync[1];
`else
   if (clk_div < 2 || clk_div > 255) begin : g_bad_div
      $error("lmx_spi_reader: clk_div must be 2..255");
   end
   assign miso_s = spi_miso;
`endif
   // frame sequencer: spi_sclk doubles as the high/low phase flag inside SHIFT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ph       <= 8'd0;
         bits     <= 5'd0;
         frame    <= 24'd0;
         sh       <= 16'd0;
         rd_ready <= 1'b1;
         rd_valid <= 1'b0;
         rd_data  <= 16'd0;
         spi_le   <= 1'b1;
         spi_sclk <= 1'b0;
         spi_mosi <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            IDLE: if (rd_start) begin
               frame    <= {1'b1, rd_addr, 16'h0000};
               state    <= LEAD;
               ph       <= 8'd0;
               rd_ready <= 1'b0;
               spi_le   <= 1'b0;
               spi_mosi <= 1'b1;
            end
            LEAD: if (ph == L - 8'd1) begin
               state    <= SHIFT;
               ph       <= 8'd0;
               bits     <= 5'd23;
               spi_sclk <= 1'b1;
            end else ph <= ph + 8'd1;
            SHIFT: if (spi_sclk) begin
               if (ph == H - 8'd1) begin
                  ph       <= 8'd0;
                  spi_sclk <= 1'b0;
                  spi_mosi <= frame[22];
                  frame    <= {frame[22:0], 1'b0};
                  if (bits <= 5'd15) sh <= {sh[14:0], miso_s};
                  if (bits == 5'd0) state <= TAIL;
               end else ph <= ph + 8'd1;
            end else if (ph == L - 8'd1) begin
               ph       <= 8'd0;
               spi_sclk <= 1'b1;
               bits     <= bits - 5'd1;
            end else ph <= ph + 8'd1;
            TAIL: if (ph == L - 8'd1) begin
               state    <= GAP;
               ph       <= 8'd0;
               spi_le   <= 1'b1;
               spi_mosi <= 1'b0;
               rd_data  <= sh;
               rd_valid <= 1'b1;
            end else ph <= ph + 8'd1;
            GAP: if (ph == P - 8'd1) begin
               state    <= IDLE;
               ph       <= 8'd0;
               rd_ready <= 1'b1;
            end else ph <= ph + 8'd1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_lmx_spi_reader.sv
// tb_lmx_spi_reader: scoreboard bench with an LMX2594 readback device model per DUT instance
module tb_lmx_spi_reader;
   localparam int N = 2;
`ifdef LMX_SPI_READER_MISO_SYNC_EN
   localparam int CDS[N] = '{6, 7};
`else
   localparam int CDS[N] = '{5, 2};
`endif
   typedef struct packed {
      logic [15:0] d;
      logic [31:0] t;
      logic [23:0] f;
   } exp_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        start[N];
   logic [6:0]  addr[N];
   logic        ready[N], valid[N], sclk[N], mosi[N], le[N];
   logic [15:0] data[N];
   logic [15:0] dev_val[N];
   exp_t        q[N][$];
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[%0d]: got %0h, expected %0h (cycle %0d)", nm, i, act, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < N; g++) begin : u
      logic        md = 0;
      logic        ps = 0;
      logic        pl = 1;
      int          rise = 0;
      int          idx;
      logic [23:0] cap = 0;
      exp_t        e;
      lmx_spi_reader #(.clk_div(CDS[g])) dut (
         .clk(clk), .rst_n(rst_n), .rd_start(start[g]), .rd_addr(addr[g]),
         .rd_ready(ready[g]), .rd_data(data[g]), .rd_valid(valid[g]),
         .spi_sclk(sclk[g]), .spi_mosi(mosi[g]), .spi_le(le[g]), .spi_miso(md)
      );
      // device: records MOSI on rising SCLK, drives readback bit after each falling SCLK
      always @(negedge clk) begin
         if (pl && !le[g]) rise = 0;
         if (!le[g] && !ps && sclk[g]) begin
            rise++;
            cap = {cap[22:0], mosi[g]};
         end
         if (!le[g] && ps && !sclk[g] && rise >= 8 && rise <= 23) begin
            idx = 23 - rise;
            md = dev_val[g][idx];
         end
         ps = sclk[g];
         pl = le[g];
      end
      // monitor: every rd_valid must match the oldest outstanding request
      always @(negedge clk) if (valid[g]) begin
         if (q[g].size() == 0) chk("unexpected_valid", g, 32'(valid[g]), 0);
         else begin
            e = q[g].pop_front();
            chk("rd_data", g, 32'(data[g]), 32'(e.d));
            chk("valid_cycle", g, cyc, e.t);
            chk("mosi_frame", g, 32'(cap), 32'(e.f));
            chk("sclk_rises", g, rise, 24);
         end
      end
   end

   task automatic frame(input int i, input logic [6:0] a, input logic [15:0] v, input bit glitch);
      int c0, n, cd, l;
      cd = CDS[i];
      l = (cd + 1) / 2;
      n = 0;
      while (!ready[i] && n < 2000) begin @(posedge clk); #1; n++; end
      chk("idle_timeout", i, 32'(ready[i]), 1);
      c0 = cyc;
      dev_val[i] = v;
      addr[i] = a;
      start[i] = 1;
      q[i].push_back({v, 32'(c0 + 1 + l + 24 * cd), {1'b1, a, 16'h0000}});
      @(posedge clk); #1;
      start[i] = 0;
      addr[i] = 7'($urandom);
      chk("ready_low", i, 32'(ready[i]), 0);
      n = 0;
      while (!ready[i] && n < 2000) begin
         start[i] = glitch && (cyc - c0 == 10 || cyc - c0 == 60);
         if (start[i]) addr[i] = 7'($urandom);
         @(posedge clk); #1;
         n++;
      end
      start[i] = 0;
      chk("ready_cycle", i, cyc, 32'(c0 + 1 + l + 25 * cd));
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         start[i] = 0;
         addr[i] = 0;
         dev_val[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         chk("rst_ready", i, 32'(ready[i]), 1);
         chk("rst_valid", i, 32'(valid[i]), 0);
         chk("rst_data", i, 32'(data[i]), 0);
         chk("rst_le", i, 32'(le[i]), 1);
         chk("rst_sclk", i, 32'(sclk[i]), 0);
         chk("rst_mosi", i, 32'(mosi[i]), 0);
      end
      rst_n = 1;
      @(posedge clk); #1;
      dev_val[0] = 16'h1234;
      addr[0] = 7'h11;
      start[0] = 1;
      @(posedge clk); #1;
      start[0] = 0;
      repeat (49) @(posedge clk);
      #1;
      chk("mid_frame_le", 0, 32'(le[0]), 0);
      rst_n = 0;
      #1;
      chk("abort_le", 0, 32'(le[0]), 1);
      chk("abort_sclk", 0, 32'(sclk[0]), 0);
      chk("abort_ready", 0, 32'(ready[0]), 1);
      chk("abort_valid", 0, 32'(valid[0]), 0);
      chk("abort_data", 0, 32'(data[0]), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      frame(0, 7'h00, 16'hA5C3, 0);
      frame(0, 7'h7F, 16'hFFFF, 0);
      frame(1, 7'h05, 16'h0001, 0);
      frame(0, 7'h2A, 16'h5A5A, 1);
      frame(1, 7'h33, 16'h5A5A, 0);
      for (int r = 0; r < 24; r++) frame(r % 2, 7'($urandom), 16'($urandom), r % 5 == 0);
      repeat (300) @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) chk("pending", i, q[i].size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
